// File: rtl/tracer_pkg.sv
// Shared types and helpers for the tracer uDMA streamer: datasize codes, FSM states,
// and the beat-count calculation.
package tracer_pkg;

    localparam logic [1:0] DSIZE_8  = 2'd0;
    localparam logic [1:0] DSIZE_16 = 2'd1;
    localparam logic [1:0] DSIZE_32 = 2'd2;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } streamer_state_e;

    // Number of DATA_WIDTH beats needed to carry len bytes.
    function automatic int unsigned beats_for_len(input int unsigned len,
                                                  input int unsigned data_width);
        return (len * 8 + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/tracer_pkt_fifo.sv
// Packet FIFO for the tracer streamer. A pop in the same cycle frees a slot, so a push
// into a full FIFO is still accepted when it coincides with a pop.
module tracer_pkt_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (PtrW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/tracer_udma_streamer.sv
// Buffers variable-length trace packets and serialises them LSB-first into DATA_WIDTH
// beats on the uDMA RX channel, with drop statistics for packets lost to a full FIFO.
module tracer_udma_streamer
    import tracer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_WIDTH  = 128,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic                               flush_i,
    input  logic [PKT_WIDTH-1:0]               pkt_data_i,
    input  logic [$clog2(PKT_WIDTH/8):0]       pkt_len_i,
    input  logic                               pkt_valid_i,
    output logic                               pkt_ready_o,
    output logic [1:0]                         data_rx_datasize_o,
    output logic [DATA_WIDTH-1:0]              data_rx_data_o,
    output logic                               data_rx_valid_o,
    input  logic                               data_rx_ready_i,
    output logic                               overflow_o,
    output logic [CNT_WIDTH-1:0]               drop_cnt_o,
    input  logic                               clr_stat_i,
    output logic                               busy_o
);

    localparam int unsigned PktBytes = PKT_WIDTH / 8;
    localparam int unsigned LenW     = $clog2(PktBytes) + 1;
    localparam int unsigned BeatW    = $clog2(PKT_WIDTH / DATA_WIDTH) + 1;
    localparam logic [1:0]  DSize    = (DATA_WIDTH == 8)  ? DSIZE_8  :
                                       (DATA_WIDTH == 16) ? DSIZE_16 : DSIZE_32;

    streamer_state_e        state_q, state_d;
    logic [PKT_WIDTH-1:0]   shift_q, shift_d;
    logic [BeatW-1:0]       beats_q, beats_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic [PKT_WIDTH-1:0]      pkt_masked;
    logic [PKT_WIDTH+LenW-1:0] fifo_rdata;
    logic [PKT_WIDTH-1:0]      head_data;
    logic [LenW-1:0]           head_len;
    logic                      fifo_full, fifo_empty, fifo_pop;
    logic                      len_ok, offer, drop;

    assign pkt_ready_o        = enable_i & ~flush_i;
    assign data_rx_datasize_o = DSize;
    assign len_ok = (pkt_len_i != '0) && (pkt_len_i <= LenW'(PktBytes));
    assign offer  = pkt_valid_i & pkt_ready_o & len_ok;
    assign drop   = offer & fifo_full & ~fifo_pop;

    // Bytes past len are zeroed on entry so the last beat carries zero padding.
    always_comb begin
        pkt_masked = '0;
        for (int b = 0; b < int'(PktBytes); b++) begin
            if (b < int'(pkt_len_i)) pkt_masked[b*8 +: 8] = pkt_data_i[b*8 +: 8];
        end
    end

    tracer_pkt_fifo #(
        .Width (PKT_WIDTH + LenW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (offer),
        .wdata_i ({pkt_len_i, pkt_masked}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_data = fifo_rdata[PKT_WIDTH-1:0];
    assign head_len  = fifo_rdata[PKT_WIDTH +: LenW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            beats_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            beats_q    <= beats_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        beats_d  = beats_q;
        fifo_pop = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            shift_d = '0;
            beats_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = head_data;
                        beats_d  = BeatW'(beats_for_len(32'(head_len), DATA_WIDTH));
                        state_d  = StSend;
                    end
                end
                StSend: begin
                    if (data_rx_ready_i) begin
                        if (beats_q == BeatW'(1)) begin
                            // Chain straight into the next packet to avoid a bubble.
                            if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                shift_d  = head_data;
                                beats_d  = BeatW'(beats_for_len(32'(head_len), DATA_WIDTH));
                            end else begin
                                shift_d = '0;
                                beats_d = '0;
                                state_d = StIdle;
                            end
                        end else begin
                            shift_d = shift_q >> DATA_WIDTH;
                            beats_d = beats_q - BeatW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        data_rx_valid_o = (state_q == StSend);
        data_rx_data_o  = (state_q == StSend) ? shift_q[DATA_WIDTH-1:0] : '0;
        busy_o          = ~fifo_empty | (state_q != StIdle);
    end

    // A clear coincident with a drop wins.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_stat_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tracer_udma_streamer.sv
// Directed bench for tracer_udma_streamer with default parameters (32-bit beats,
// 16-byte packets, 8-entry FIFO).
module tb_tracer_udma_streamer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] pkt_data = '0;
    logic [4:0]   pkt_len = '0;
    logic         pkt_valid = 1'b0;
    logic         pkt_ready;
    logic [1:0]   dsize;
    logic [31:0]  rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic         clr = 1'b0;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tracer_udma_streamer dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .enable_i           (enable),
        .flush_i            (flush),
        .pkt_data_i         (pkt_data),
        .pkt_len_i          (pkt_len),
        .pkt_valid_i        (pkt_valid),
        .pkt_ready_o        (pkt_ready),
        .data_rx_datasize_o (dsize),
        .data_rx_data_o     (rx_data),
        .data_rx_valid_o    (rx_valid),
        .data_rx_ready_i    (rx_ready),
        .overflow_o         (overflow),
        .drop_cnt_o         (drop_cnt),
        .clr_stat_i         (clr),
        .busy_o             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic [4:0] l);
        pkt_data  = d;
        pkt_len   = l;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 32'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cnt", drop_cnt, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("dsize", dsize, 2'd2);
        rst = 1'b0;
        enable = 1'b1;
        tick();
        chk("ready_en", pkt_ready, 1'b1);

        // 1: single 16B packet, continuous ready
        rx_ready = 1'b1;
        push(128'h0f0e0d0c_0b0a0908_07060504_03020100, 5'd16);
        chk("t1_busy_queued", busy, 1'b1);
        chk("t1_not_yet_valid", rx_valid, 1'b0);
        tick();
        chk("t1_b0_valid", rx_valid, 1'b1);
        chk("t1_b0", rx_data, 32'h03020100);
        tick();
        chk("t1_b1", rx_data, 32'h07060504);
        tick();
        chk("t1_b2", rx_data, 32'h0b0a0908);
        tick();
        chk("t1_b3_valid", rx_valid, 1'b1);
        chk("t1_b3", rx_data, 32'h0f0e0d0c);
        tick();
        chk("t1_end_valid", rx_valid, 1'b0);

        // 2: 5B packet, upper bytes must be zero padded
        push(128'hdeadbeef_deadbeef_deadbe44_33221100, 5'd5);
        tick();
        chk("t2_b0", rx_data, 32'h33221100);
        tick();
        chk("t2_b1", rx_data, 32'h00000044);
        tick();
        chk("t2_end_valid", rx_valid, 1'b0);
        chk("t2_busy", busy, 1'b0);

        // 3: ready toggling, beats held while ready low
        rx_ready = 1'b0;
        push(128'h1f1e1d1c_1b1a1918_17161514_13121110, 5'd16);
        tick();
        chk("t3_b0_hold", rx_data, 32'h13121110);
        rx_ready = 1'b1; tick();
        chk("t3_b1", rx_data, 32'h17161514);
        rx_ready = 1'b0; tick();
        chk("t3_b1_hold", rx_data, 32'h17161514);
        rx_ready = 1'b1; tick();
        chk("t3_b2", rx_data, 32'h1b1a1918);
        rx_ready = 1'b0; tick();
        chk("t3_b2_hold", rx_data, 32'h1b1a1918);
        rx_ready = 1'b1; tick();
        chk("t3_b3", rx_data, 32'h1f1e1d1c);
        chk("t3_b3_valid", rx_valid, 1'b1);
        rx_ready = 1'b0; tick();
        chk("t3_b3_hold", rx_data, 32'h1f1e1d1c);
        rx_ready = 1'b1; tick();
        chk("t3_end_valid", rx_valid, 1'b0);

        // 4: overflow with the serialiser already holding a stalled packet
        rx_ready = 1'b0;
        push(128'h0, 5'd4);
        tick();
        chk("t4_hold_valid", rx_valid, 1'b1);
        for (int i = 0; i < 10; i++) push(128'(i + 1), 5'd4);
        chk("t4_cnt", drop_cnt, 16'd2);
        chk("t4_ovf", overflow, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr_cnt", drop_cnt, 16'd0);
        chk("t4_clr_ovf", overflow, 1'b0);
        clr = 1'b1;
        push(128'h55, 5'd4);
        clr = 1'b0;
        chk("t4_clr_wins_cnt", drop_cnt, 16'd0);
        chk("t4_clr_wins_ovf", overflow, 1'b0);
        push(128'h66, 5'd4);
        chk("t4_drop_again", drop_cnt, 16'd1);
        enable = 1'b0;
        pkt_valid = 1'b1;
        #1;
        chk("t4_ready_dis", pkt_ready, 1'b0);
        tick();
        pkt_valid = 1'b0;
        chk("t4_dis_not_counted", drop_cnt, 16'd1);
        enable = 1'b1;
        push(128'h77, 5'd0);
        push(128'h88, 5'd17);
        chk("t4_badlen_not_counted", drop_cnt, 16'd1);
        flush = 1'b1;
        #1;
        chk("t4_ready_flush", pkt_ready, 1'b0);
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", rx_valid, 1'b0);
        chk("t4_flush_busy", busy, 1'b0);
        chk("t4_flush_keeps_cnt", drop_cnt, 16'd1);
        chk("t4_flush_keeps_ovf", overflow, 1'b1);

        // 5: two queued 8B packets stream back to back
        rx_ready = 1'b1;
        push(128'ha7a6a5a4_a3a2a1a0, 5'd8);
        push(128'hb7b6b5b4_b3b2b1b0, 5'd8);
        chk("t5_a0", rx_data, 32'ha3a2a1a0);
        tick();
        chk("t5_a1", rx_data, 32'ha7a6a5a4);
        tick();
        chk("t5_b0_valid", rx_valid, 1'b1);
        chk("t5_b0", rx_data, 32'hb3b2b1b0);
        tick();
        chk("t5_b1", rx_data, 32'hb7b6b5b4);
        tick();
        chk("t5_end_valid", rx_valid, 1'b0);

        // 6: flush mid-packet truncates it and drops the queued one
        push(128'hcfcecdcc_cbcac9c8_c7c6c5c4_c3c2c1c0, 5'd16);
        push(128'hdfdedddc_dbdad9d8_d7d6d5d4_d3d2d1d0, 5'd16);
        chk("t6_c0", rx_data, 32'hc3c2c1c0);
        tick();
        chk("t6_c1", rx_data, 32'hc7c6c5c4);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_flush_valid", rx_valid, 1'b0);
        chk("t6_flush_data", rx_data, 32'h0);
        chk("t6_flush_busy", busy, 1'b0);
        push(128'hefeeedec_ebeae9e8_e7e6e5e4_e3e2e1e0, 5'd16);
        tick();
        chk("t6_e0", rx_data, 32'he3e2e1e0);
        tick();
        chk("t6_e1", rx_data, 32'he7e6e5e4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
